// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side pointer, empty/almost-empty flags and occupancy for the async FIFO.
// Define FIFO_RD_UNDERFLOW_EN to add sticky underflow reporting with a saturating counter.
module fifo_rd_ctrl #(
    parameter int DEPTH         = 8,
    parameter int ADDR_WIDTH    = $clog2(DEPTH),
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  rinc,
    input  logic [ADDR_WIDTH:0]   rq2_wptr,
`ifdef FIFO_RD_UNDERFLOW_EN
    input  logic                  clr_err,
    output logic                  underflow,
    output logic [7:0]            underflow_cnt,
`endif
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_level
);
    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] rbin_q, rbin_d, rptr_q, rptr_d, level_q, level_d, wbin;
    logic          empty_q, empty_d, aempty_q, aempty_d;

    always_comb begin
        wbin = '0;
        for (int i = 0; i < PW; i++) wbin[i] = ^(rq2_wptr >> i);
        rbin_d   = rbin_q + PW'(rd_en);
        rptr_d   = (rbin_d >> 1) ^ rbin_d;
        empty_d  = rptr_d == rq2_wptr;
        // Full and empty differ only in the MSB, so modular subtraction yields 0..DEPTH.
        level_d  = wbin - rbin_d;
        aempty_d = level_d <= PW'(AEMPTY_THRESH);
    end

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            rbin_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
        end else begin
            rbin_q   <= rbin_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
        end
    end

    assign rd_en        = rinc && !empty_q;
    assign r_addr       = rbin_q[ADDR_WIDTH-1:0];
    assign rptr         = rptr_q;
    assign empty        = empty_q;
    assign almost_empty = aempty_q;
    assign rd_level     = level_q;

`ifdef FIFO_RD_UNDERFLOW_EN
    logic       uf_q;
    logic [7:0] uf_cnt_q;

    // Clear takes priority over a coincident underflow.
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            uf_q     <= 1'b0;
            uf_cnt_q <= '0;
        end else if (clr_err) begin
            uf_q     <= 1'b0;
            uf_cnt_q <= '0;
        end else if (rinc && empty_q) begin
            uf_q     <= 1'b1;
            uf_cnt_q <= uf_cnt_q + 8'(uf_cnt_q != 8'hFF);
        end
    end

    assign underflow     = uf_q;
    assign underflow_cnt = uf_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: table vectors, hand sequences and random traffic against an occupancy-count model.
module tb_fifo_rd_ctrl;
    logic       r_clk = 1'b0, r_rst = 1'b0, rinc = 1'b0;
    logic [3:0] rq2_wptr = '0;
    logic       rd_en, empty, almost_empty;
    logic [2:0] r_addr;
    logic [3:0] rptr, rd_level;
`ifdef FIFO_RD_UNDERFLOW_EN
    logic       clr_err = 1'b0, underflow;
    logic [7:0] underflow_cnt;
    bit         m_uf = 0;
    int         m_cnt = 0;
`endif

    fifo_rd_ctrl #(.DEPTH(8), .AEMPTY_THRESH(2)) dut (
        .r_clk(r_clk), .r_rst(r_rst), .rinc(rinc), .rq2_wptr(rq2_wptr),
`ifdef FIFO_RD_UNDERFLOW_EN
        .clr_err(clr_err), .underflow(underflow), .underflow_cnt(underflow_cnt),
`endif
        .rd_en(rd_en), .r_addr(r_addr), .rptr(rptr), .empty(empty),
        .almost_empty(almost_empty), .rd_level(rd_level)
    );

    always #5 r_clk = ~r_clk;

    int n_tests = 0, n_fail = 0;
    // Model: total reads/writes modulo 16; occupancy is their difference.
    int m_rd = 0, m_wr = 0, m_level = 0;
    bit m_empty = 1;
    logic last_rd_en;

    function automatic logic [3:0] gray(input int b);
        logic [3:0] v;
        v = b[3:0];
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("rptr", rptr, gray(m_rd));
        check("r_addr", r_addr, m_rd % 8);
        check("rd_level", rd_level, m_level);
        check("empty", empty, m_empty);
        check("almost_empty", almost_empty, m_level <= 2);
`ifdef FIFO_RD_UNDERFLOW_EN
        check("underflow", underflow, m_uf);
        check("underflow_cnt", underflow_cnt, m_cnt);
`endif
    endtask

    task automatic step_model(input bit r);
        bit acc;
        acc = r && !m_empty;
`ifdef FIFO_RD_UNDERFLOW_EN
        if (clr_err) begin
            m_uf = 0;
            m_cnt = 0;
        end else if (r && m_empty) begin
            m_uf = 1;
            if (m_cnt < 255) m_cnt++;
        end
`endif
        m_rd = (m_rd + int'(acc)) % 16;
        m_level = (m_wr + 16 - m_rd) % 16;
        m_empty = (m_level == 0);
    endtask

    task automatic drive(input bit r, input int wb);
        @(negedge r_clk);
        rinc = r;
        m_wr = wb % 16;
        rq2_wptr = gray(m_wr);
        #1;
        last_rd_en = rd_en;
        check("rd_en", rd_en, r && !m_empty);
        @(posedge r_clk);
        step_model(r);
        #1 check_outputs();
    endtask

    // Asserts reset between edges, holds it with random inputs, releases with write pointer wb.
    task automatic do_reset(input int wb, input int cycles);
        @(negedge r_clk);
        #2 r_rst = 1'b0;
        m_rd = 0;
        m_level = 0;
        m_empty = 1;
`ifdef FIFO_RD_UNDERFLOW_EN
        m_uf = 0;
        m_cnt = 0;
`endif
        #1;
        check_outputs();
        check("rst_rd_en", rd_en, 0);
        repeat (cycles) begin
            @(negedge r_clk);
            rinc = 1'($urandom);
            rq2_wptr = 4'($urandom);
            #1;
            check_outputs();
            check("rst_rd_en", rd_en, 0);
        end
        @(negedge r_clk);
        rinc = 1'b0;
        m_wr = wb % 16;
        rq2_wptr = gray(m_wr);
        r_rst = 1'b1;
        @(posedge r_clk);
        step_model(0);
        #1 check_outputs();
    endtask

    typedef struct {
        bit pre_rst; bit r; int wb;
        bit en; int rptr; int addr; int lvl; bit e; bit ae;
    } vec_t;
    vec_t tbl[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{0, 0, 3, 0, 0,  0, 3, 0, 0};
        tbl[1]  = '{0, 1, 3, 1, 1,  1, 2, 0, 1};
        tbl[2]  = '{0, 1, 3, 1, 3,  2, 1, 0, 1};
        tbl[3]  = '{0, 1, 3, 1, 2,  3, 0, 1, 1};
        tbl[4]  = '{0, 1, 3, 0, 2,  3, 0, 1, 1};
        tbl[5]  = '{1, 0, 8, 0, 0,  0, 8, 0, 0};
        tbl[6]  = '{0, 1, 8, 1, 1,  1, 7, 0, 0};
        tbl[7]  = '{0, 1, 8, 1, 3,  2, 6, 0, 0};
        tbl[8]  = '{0, 1, 8, 1, 2,  3, 5, 0, 0};
        tbl[9]  = '{0, 1, 8, 1, 6,  4, 4, 0, 0};
        tbl[10] = '{0, 1, 8, 1, 7,  5, 3, 0, 0};
        tbl[11] = '{0, 1, 8, 1, 5,  6, 2, 0, 1};
        tbl[12] = '{0, 1, 8, 1, 4,  7, 1, 0, 1};
        tbl[13] = '{0, 1, 8, 1, 12, 0, 0, 1, 1};

        do_reset(0, 3);

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].pre_rst) do_reset(0, 2);
            drive(tbl[i].r, tbl[i].wb);
            check($sformatf("tbl%0d_rd_en", i), last_rd_en, tbl[i].en);
            check($sformatf("tbl%0d_rptr", i), rptr, tbl[i].rptr);
            check($sformatf("tbl%0d_addr", i), r_addr, tbl[i].addr);
            check($sformatf("tbl%0d_level", i), rd_level, tbl[i].lvl);
            check($sformatf("tbl%0d_empty", i), empty, tbl[i].e);
            check($sformatf("tbl%0d_aempty", i), almost_empty, tbl[i].ae);
        end

        for (int i = 0; i < 20; i++)
            drive(i % 4 != 3, m_wr + int'(i % 3 != 2));

`ifdef FIFO_RD_UNDERFLOW_EN
        for (int i = 0; i < 10 && !m_empty; i++) drive(1, m_wr);
        clr_err = 1'b1;
        drive(0, m_wr);
        clr_err = 1'b0;
        drive(1, m_wr);
        drive(1, m_wr);
        check("uf_set", underflow, 1);
        check("uf_cnt2", underflow_cnt, 2);
        clr_err = 1'b1;
        drive(1, m_wr);
        clr_err = 1'b0;
        check("uf_clr", underflow, 0);
        check("uf_cnt_clr", underflow_cnt, 0);
`endif

        do_reset(0, 2);
        drive(0, 5);
        check("pre_rst_level5", rd_level, 5);
        do_reset(5, 0);
        check("post_rst_level5", rd_level, 5);
        check("post_rst_empty", empty, 0);

        for (int i = 0; i < 400; i++) begin
            int cur, k;
            if (i % 150 == 149) do_reset(0, 1);
            cur = (m_wr + 16 - m_rd) % 16;
            k = $urandom_range(0, (8 - cur) < 3 ? (8 - cur) : 3);
`ifdef FIFO_RD_UNDERFLOW_EN
            clr_err = ($urandom_range(0, 15) == 0);
`endif
            drive(1'($urandom_range(0, 1)), m_wr + k);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller for the dual-clock (async) FIFO, r_clk domain.
- Owns the binary/Gray read pointer and generates the memory read address and read enable.
- Compares against the 2-flop-synchronised write Gray pointer to produce registered empty, almost_empty and an occupancy level.
- Parametrised successor of the basic read-pointer block: configurable depth and almost-empty threshold, registered flags, and occupancy output.
- Optional underflow error reporting.

Parameters:
DEPTH, 8, FIFO entries; must be a power of 2, minimum 4
ADDR_WIDTH, $clog2(DEPTH), memory address width; pointers are ADDR_WIDTH+1 bits
AEMPTY_THRESH, 2, almost_empty asserted when level <= this value; range 0..DEPTH-1

Ports:
r_clk  in  1  read-domain clock
r_rst  in  1  asynchronous, active-low reset
rinc  in  1  read request
rq2_wptr  in  ADDR_WIDTH+1  write Gray pointer, already double-synchronised into r_clk
rd_en  out  1  memory read enable = rinc && !empty (combinational)
r_addr  out  ADDR_WIDTH  memory read address = rbin[ADDR_WIDTH-1:0]
rptr  out  ADDR_WIDTH+1  registered Gray read pointer, to write-domain synchroniser
empty  out  1  registered empty flag
almost_empty  out  1  registered, level <= AEMPTY_THRESH
rd_level  out  ADDR_WIDTH+1  registered occupancy as seen by the read side, 0..DEPTH

Behaviour:
Reset (r_rst low, asynchronous) forces the following regardless of clock:
- rbin=0, rptr=0, empty=1, almost_empty=1, rd_level=0, r_addr=0.
- Asserting reset mid-operation drops all state immediately; the first edge after release behaves as if from reset.

Pointer update:
- Read accepted when rinc && !empty.
- rbin_next = rbin + accepted, modulo 2^(ADDR_WIDTH+1).
- rgray_next = (rbin_next >> 1) ^ rbin_next.
- rbin and rptr are both registered on the same edge; rptr is never driven combinationally.

Empty:
- empty <= (rgray_next == rq2_wptr).
- Deasserts one r_clk after rq2_wptr changes.
- Asserts on the same edge that consumes the last word.

Level:
- rq2_wbin = gray2bin(rq2_wptr), combinational XOR-prefix.
- rd_level <= rq2_wbin - rbin_next, modulo 2^(ADDR_WIDTH+1).
- almost_empty <= (that same next level <= AEMPTY_THRESH).

Boundary conditions:
- Wrap: the pointer MSB toggles every DEPTH reads; r_addr wraps DEPTH-1 -> 0. Full (level=DEPTH) is distinguished from empty by the MSB.
- rinc while empty: ignored. Pointer holds, rd_en=0.
- rq2_wptr may jump by more than one position between cycles (synchroniser lag). Level follows, never exceeds DEPTH under legal write-side operation.
- rinc and a write-pointer change in the same cycle: both are applied in the next-state computation.
- Latency: rinc to r_addr/rptr advance is 1 cycle. Write-pointer change to empty/level is 1 cycle after rq2_wptr.

Optional Feature:
Macro: FIFO_RD_UNDERFLOW_EN

With the macro defined, the block adds:
- Input clr_err (1 bit).
- Output underflow (1 bit, sticky): set on any edge where rinc && empty.
- Output underflow_cnt (8 bits): increments on the same condition, saturates at 255.
- clr_err clears both synchronously. If clr_err and a new underflow coincide, the clear wins for that cycle.
- Both outputs reset to 0.

Without the macro: these ports and registers are absent, and underflow attempts are silently ignored.

Test Plan:
All scenarios use DEPTH=8, AEMPTY_THRESH=2.
1. Reset: hold r_rst=0 with random rinc/rq2_wptr -> empty=1, almost_empty=1, rptr=0000, r_addr=0, rd_level=0, rd_en=0.
2. Drain 3 words: rq2_wptr=0010 (bin 3).
   - Next cycle: empty=0, rd_level=3, almost_empty=0.
   - rinc for 3 cycles: r_addr 0,1,2; rptr 0001,0011,0010; rd_level 2,1,0; almost_empty=1 from the first read.
   - empty=1 after the third edge.
3. Full view: rq2_wptr=1100 (bin 8) -> rd_level=8, almost_empty=0, empty=0. Continuous rinc for 8 cycles -> empty=1 exactly after the 8th read; rptr=1100.
4. Wrap: 20 interleaved write-pointer steps and reads crossing rbin 15 -> 0.
   - rptr 1000 -> 0000 and r_addr 7 -> 0 at the crossing.
   - rd_level and empty are correct throughout.
5. Underflow (FIFO_RD_UNDERFLOW_EN): while empty, rinc=1 for 2 cycles -> rptr unchanged, rd_en=0, underflow=1, underflow_cnt=2. Then clr_err=1 -> both 0.
6. Reset mid-stream: rd_level=5, assert r_rst between clock edges -> outputs reach reset values without waiting for a clock edge. After release with rq2_wptr still non-zero -> empty=0 and rd_level reflects rq2_wptr on the first edge.
